// File: rtl/weighted_round_robin.sv
// weighted_round_robin
//   Weighted round-robin pop scheduler for a bank of QUEUE_QUANTITY queues.
//   Each grant is a burst of up to eff_w(queue) pops. A weight of 0 is
//   treated as 1. When a burst ends on a pop, the next queue is granted on the
//   same edge, so there is no bubble. When the granted queue runs empty, the
//   switch costs one bubble cycle.
//
// Ports
//   clk, rst    clock; asynchronous active-high reset
//   enb         global enable; 0 freezes scheduling state and gates out_enb
//   buf_empty   per-queue empty flags (bit i = queue i)
//   down_full   downstream backpressure; blocks pops and switches while in SERVE
//   cfg_load    load weight_cfg into the weight registers on this edge
//   weight_cfg  packed weights, queue i in [i*WEIGHT_BITS +: WEIGHT_BITS]
//   selector    granted queue (registered); drives the queue read mux
//   out_enb     pop strobe (combinational); queue[selector] pops on the edge
//   credit      pops remaining in the current burst (registered)
//   idle        scheduler is in IDLE
module weighted_round_robin #(
  parameter  int QUEUE_QUANTITY = 4,
  parameter  int WEIGHT_BITS    = 3,
  localparam int SEL_W          = (QUEUE_QUANTITY > 1) ? $clog2(QUEUE_QUANTITY) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enb,
  input  logic [QUEUE_QUANTITY-1:0]            buf_empty,
  input  logic                                 down_full,
  input  logic                                 cfg_load,
  input  logic [QUEUE_QUANTITY*WEIGHT_BITS-1:0] weight_cfg,
  output logic [SEL_W-1:0]                     selector,
  output logic                                 out_enb,
  output logic [WEIGHT_BITS-1:0]               credit,
  output logic                                 idle
);

  typedef enum logic {S_IDLE = 1'b0, S_SERVE = 1'b1} state_t;

  state_t                                  r_state;
  logic [SEL_W-1:0]                        r_selector;
  logic [WEIGHT_BITS-1:0]                  r_credit;
  logic [QUEUE_QUANTITY-1:0][WEIGHT_BITS-1:0] r_weight;

  logic [QUEUE_QUANTITY-1:0][WEIGHT_BITS-1:0] w_eff_w;
  logic                                    w_found;
  logic [SEL_W-1:0]                        w_next_sel;
  logic                                    w_pop;
  logic                                    w_switch;
  state_t                                  w_state_nxt;
  logic [SEL_W-1:0]                        w_sel_nxt;
  logic [WEIGHT_BITS-1:0]                  w_credit_nxt;

  // Weight registers load independently of enb/state. A running burst keeps
  // its credit, and the new weight is used at the next reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_QUANTITY; i++) r_weight[i] <= WEIGHT_BITS'(1);
    end else if (cfg_load) begin
      r_weight <= weight_cfg;
    end
  end

  // Zero weight still grants one pop, so a configured queue is never starved.
  for (genvar g = 0; g < QUEUE_QUANTITY; g++) begin : g_eff
    assign w_eff_w[g] = (r_weight[g] == '0) ? WEIGHT_BITS'(1) : r_weight[g];
  end

  // Scan selector+1 .. selector+QUEUE_QUANTITY (the current queue is last).
  // The loop walks from farthest to nearest so that the nearest hit wins.
  always_comb begin
    logic [SEL_W:0]   sum;
    logic [SEL_W-1:0] idx;
    w_found    = 1'b0;
    w_next_sel = r_selector;
    for (int k = QUEUE_QUANTITY; k >= 1; k--) begin
      sum = {1'b0, r_selector} + (SEL_W+1)'(k);
      idx = (sum >= (SEL_W+1)'(QUEUE_QUANTITY)) ?
            SEL_W'(sum - (SEL_W+1)'(QUEUE_QUANTITY)) : SEL_W'(sum);
      if (!buf_empty[idx]) begin
        w_found    = 1'b1;
        w_next_sel = idx;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_selector <= '0;
      r_credit   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_selector <= w_sel_nxt;
      r_credit   <= w_credit_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_selector;
    w_credit_nxt = r_credit;
    w_switch     = 1'b0;
    if (enb) begin
      case (r_state)
        S_IDLE:  w_switch = w_found;
        S_SERVE: begin
          if (!down_full) begin
            if (w_pop && (r_credit > WEIGHT_BITS'(1)))
              w_credit_nxt = r_credit - WEIGHT_BITS'(1);
            else
              // Last pop of the burst, or the granted queue ran dry.
              w_switch = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
    if (w_switch) begin
      if (w_found) begin
        w_state_nxt  = S_SERVE;
        w_sel_nxt    = w_next_sel;
        w_credit_nxt = w_eff_w[w_next_sel];
      end else begin
        w_state_nxt  = S_IDLE;
        w_credit_nxt = '0;
      end
    end
  end

  // Outputs. out_enb is gated by the registered state, so an asserted reset
  // drops it immediately.
  always_comb begin
    w_pop = (r_state == S_SERVE) && enb && !down_full &&
            !buf_empty[r_selector] && (r_credit != '0);
    out_enb  = w_pop;
    idle     = (r_state == S_IDLE);
    selector = r_selector;
    credit   = r_credit;
  end

endmodule

// File: tb/tb_weighted_round_robin.sv
module tb_weighted_round_robin;
  localparam int Q  = 4;
  localparam int WB = 3;

  logic          clk = 1'b0;
  logic          rst, enb, down_full, cfg_load;
  logic [Q-1:0]  buf_empty;
  logic [Q*WB-1:0] weight_cfg;
  logic [1:0]    selector;
  logic          out_enb;
  logic [WB-1:0] credit;
  logic          idle;

  weighted_round_robin #(.QUEUE_QUANTITY(Q), .WEIGHT_BITS(WB)) dut (
    .clk(clk), .rst(rst), .enb(enb), .buf_empty(buf_empty),
    .down_full(down_full), .cfg_load(cfg_load), .weight_cfg(weight_cfg),
    .selector(selector), .out_enb(out_enb), .credit(credit), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  // Reference model: queue occupancies plus scheduler position.
  int cnt[Q];
  int m_w[Q];
  bit m_idle;
  int m_sel, m_cred;
  bit rec;
  int pops[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int nxt(int c);
    for (int k = 1; k <= Q; k++) begin
      int j;
      j = (c + k) % Q;
      if (cnt[j] > 0) return j;
    end
    return -1;
  endfunction

  function automatic int eff(int i);
    return (m_w[i] == 0) ? 1 : m_w[i];
  endfunction

  function automatic logic [Q*WB-1:0] pack(int a, int b, int c, int d);
    logic [Q*WB-1:0] r;
    r[0*WB +: WB] = WB'(a);
    r[1*WB +: WB] = WB'(b);
    r[2*WB +: WB] = WB'(c);
    r[3*WB +: WB] = WB'(d);
    return r;
  endfunction

  task automatic model_reset();
    m_idle = 1'b1; m_sel = 0; m_cred = 0;
    for (int i = 0; i < Q; i++) m_w[i] = 1;
  endtask

  task automatic check_outs(input string tag, input bit exp_pop);
    chk({tag, ".out_enb"},  32'(out_enb),  32'(exp_pop));
    chk({tag, ".selector"}, 32'(selector), 32'(m_sel));
    chk({tag, ".credit"},   32'(credit),   32'(m_cred));
    chk({tag, ".idle"},     32'(idle),     32'(m_idle));
  endtask

  // One clock: drive at negedge, check just after, advance model at posedge.
  task automatic cycle(input bit e, input bit df, input bit cl, input logic [Q*WB-1:0] cfg);
    bit p, nidle, sw;
    int ns, nc, j;
    @(negedge clk);
    enb = e; down_full = df; cfg_load = cl; weight_cfg = cfg;
    for (int i = 0; i < Q; i++) buf_empty[i] = (cnt[i] == 0);
    #1;
    p = !m_idle && e && !df && (cnt[m_sel] > 0) && (m_cred != 0);
    check_outs("cyc", p);
    nidle = m_idle; ns = m_sel; nc = m_cred; sw = 1'b0;
    if (e) begin
      if (m_idle) sw = (nxt(m_sel) >= 0);
      else if (!df) begin
        if (p && m_cred > 1) nc = m_cred - 1;
        else sw = 1'b1;
      end
    end
    if (sw) begin
      j = nxt(m_sel);
      if (j >= 0) begin nidle = 1'b0; ns = j; nc = eff(j); end
      else begin nidle = 1'b1; nc = 0; end
    end
    @(posedge clk);
    if (p) begin
      cnt[m_sel]--;
      if (rec) pops.push_back(m_sel);
    end
    if (cl) for (int i = 0; i < Q; i++) m_w[i] = int'(cfg[i*WB +: WB]);
    m_idle = nidle; m_sel = ns; m_cred = nc;
  endtask

  // Reset pulse that starts between edges and is held across one posedge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outs("rst_async", 1'b0);
    @(posedge clk); #1;
    check_outs("rst_held", 1'b0);
    @(negedge clk);
    enb = 1'b0; cfg_load = 1'b0; down_full = 1'b0;
    rst = 1'b0;
  endtask

  int pat[7] = '{1, 2, 2, 3, 0, 0, 0};

  initial begin
    rst = 1'b1; enb = 1'b0; down_full = 1'b0; cfg_load = 1'b0;
    weight_cfg = '0; buf_empty = '1; rec = 1'b0;
    for (int i = 0; i < Q; i++) cnt[i] = 0;
    model_reset();
    #1;
    check_outs("reset", 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Empty bank, enabled: stays idle.
    repeat (3) cycle(1, 0, 0, '0);

    // Equal weights, all queues busy.
    for (int i = 0; i < Q; i++) cnt[i] = 100;
    repeat (10) cycle(1, 0, 0, '0);

    // Weighted pattern 1,2,2,3,0,0,0 repeating.
    async_reset();
    for (int i = 0; i < Q; i++) cnt[i] = 100;
    cycle(0, 0, 1, pack(3, 1, 2, 0));
    pops.delete(); rec = 1'b1;
    repeat (16) cycle(1, 0, 0, '0);
    rec = 1'b0;
    chk("wpat.len_ok", 32'(pops.size() >= 14), 32'(1));
    for (int k = 0; k < 14 && k < pops.size(); k++)
      chk("wpat.sel", 32'(pops[k]), 32'(pat[k % 7]));

    // Drain: q2 holds 2 entries, weight 4.
    async_reset();
    for (int i = 0; i < Q; i++) cnt[i] = 0;
    cnt[2] = 2;
    cycle(0, 0, 1, pack(1, 1, 4, 1));
    repeat (5) cycle(1, 0, 0, '0);
    #1;
    chk("drain.idle", 32'(idle), 32'(1));
    chk("drain.credit", 32'(credit), 32'(0));

    // Backpressure mid-burst at selector 0, credit 2.
    async_reset();
    for (int i = 0; i < Q; i++) cnt[i] = 0;
    cnt[0] = 50;
    cycle(0, 0, 1, pack(3, 1, 1, 1));
    cycle(1, 0, 0, '0);
    cycle(1, 0, 0, '0);
    repeat (3) cycle(1, 1, 0, '0);
    repeat (3) cycle(1, 0, 0, '0);

    // Reconfigure q0 to 5 during a burst, then reset mid-burst.
    async_reset();
    cycle(0, 0, 1, pack(3, 1, 1, 1));
    cycle(1, 0, 0, '0);
    cycle(1, 0, 0, '0);
    cycle(1, 0, 1, pack(5, 1, 1, 1));
    repeat (7) cycle(1, 0, 0, '0);
    async_reset();

    // Randomized traffic.
    for (int i = 0; i < Q; i++) cnt[i] = 0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < Q; i++)
        if ($urandom_range(3) == 0) cnt[i] += $urandom_range(1, 3);
      cycle(($urandom % 10) != 0, ($urandom % 5) == 0, ($urandom % 16) == 0, (Q*WB)'($urandom));
      if (n == 300) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
